// File: rtl/regfile_wr_arbiter_if.sv
// Bus between the register-file write sources and the write-port arbiter.
//
// Signals
//   req      requester -> arbiter  NUM_REQ       write request per requester, level
//   req_addr requester -> arbiter  NUM_REQ*4     register address, requester i at [4i+3:4i]
//   req_data requester -> arbiter  NUM_REQ*DATA_W write data, requester i at [DATA_W*i +: DATA_W]
//   stall    requester -> arbiter  1             freeze arbitration while high
//   grant    arbiter -> requester  NUM_REQ       one-hot, one-cycle acceptance pulse
//   wr_sel   arbiter -> regfile    4             register select for the 4-to-16 decoder
//   wr_en    arbiter -> regfile    1             write strobe for the selected register
//   wr_data  arbiter -> regfile    DATA_W        data to write
//   busy     arbiter -> requester  1             some request is pending and not yet granted
//
// Modports: master is the requester/datapath side, slave is the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*4-1:0]      req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      stall;
    logic [NUM_REQ-1:0]        grant;
    logic [3:0]                wr_sel;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      busy;

    modport master (
        output req, req_addr, req_data, stall,
        input  grant, wr_sel, wr_en, wr_data, busy
    );

    modport slave (
        input  req, req_addr, req_data, stall,
        output grant, wr_sel, wr_en, wr_data, busy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
//
// Each cycle the arbiter picks one requester, starting the search at the
// round-robin pointer and wrapping modulo NUM_REQ, and issues its address and
// data to the register decoder on the next edge. A requester granted in the
// current cycle sits out the following arbitration, so a lone requester is
// served every other cycle while two or more share the port at one grant per
// cycle. Writes to R0 can be swallowed (grant issued, strobe suppressed).
//
// Ports
//   clock  in  rising-edge clock
//   clear  in  synchronous active-high reset
//   bus    slave modport of regfile_wr_arbiter_if (req/req_addr/req_data/stall
//          in; grant/wr_sel/wr_en/wr_data/busy out, all registered)
module regfile_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter bit PROTECT_R0 = 1'b1
) (
    input logic                 clock,
    input logic                 clear,
    regfile_wr_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [3:0]          wr_sel_q, wr_sel_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [3:0]          addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  grant_mask;
    logic [NUM_REQ-1:0]  eligible;
    logic                any_req;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [3:0]          win_addr;
    logic [DATA_W-1:0]   win_data;

    // Split the flat request buses into per-requester lanes.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr[4*g +: 4];
        assign data_arr[g] = bus.req_data[DATA_W*g +: DATA_W];
    end

    // The requester holding this cycle's grant is excluded from the next pick,
    // which is what stops back-to-back grants to the same source.
    always_comb begin
        grant_mask = (state_q == ISSUE) ? grant_q : '0;
        eligible   = bus.req & ~grant_mask;
        any_req    = |bus.req;
    end

    // Rotating priority search starting at rr_ptr_q.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        idx       = 0;
        idx_p     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_p = PTR_W'(idx);
            if (!win_found && eligible[idx_p]) begin
                win_found = 1'b1;
                win_idx   = idx_p;
            end
        end
        win_addr = addr_arr[win_idx];
        win_data = data_arr[win_idx];
    end

    // State register: every output and the pointer are flops.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            wr_sel_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            wr_sel_q  <= wr_sel_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Next state. Stall takes priority over issuing; with no request at all
    // a stall simply leaves the arbiter idle.
    always_comb begin
        state_d = IDLE;
        if (bus.stall) begin
            if (any_req) begin
                state_d = STALLED;
            end
        end else if (win_found) begin
            state_d = ISSUE;
        end
    end

    // Outputs for the next cycle. Select and data hold when nothing issues so
    // the decoder inputs do not toggle needlessly.
    always_comb begin
        grant_d   = '0;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = |eligible;
        if (state_d == ISSUE) begin
            grant_d[win_idx] = 1'b1;
            wr_sel_d         = win_addr;
            wr_data_d        = win_data;
            // A protected R0 write is accepted (grant pulses) but never strobed.
            wr_en_d          = !(PROTECT_R0 && (win_addr == 4'd0));
            rr_ptr_d         = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
        end
    end

    assign bus.grant   = grant_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: two instances (R0 protected / unprotected)
// share one stimulus stream and are compared every cycle against a
// behavioural model of the arbitration rules, plus directed expectations.
module tb_regfile_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    regfile_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus_p ();
    regfile_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus_u ();

    regfile_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PROTECT_R0(1'b1)) dut_p (
        .clock(clock), .clear(clear), .bus(bus_p.slave));
    regfile_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PROTECT_R0(1'b0)) dut_u (
        .clock(clock), .clear(clear), .bus(bus_u.slave));

    logic [N-1:0]    req;
    logic [N*4-1:0]  req_addr;
    logic [N*DW-1:0] req_data;
    logic            stall;

    assign bus_p.req = req;  assign bus_p.req_addr = req_addr;
    assign bus_p.req_data = req_data;  assign bus_p.stall = stall;
    assign bus_u.req = req;  assign bus_u.req_addr = req_addr;
    assign bus_u.req_data = req_data;  assign bus_u.stall = stall;

    int total = 0;
    int bad   = 0;

    // Reference state: pointer, index of the requester granted this cycle (-1 none)
    int           m_ptr, m_last;
    logic [N-1:0] m_grant;
    logic [3:0]   m_sel;
    logic [DW-1:0] m_data;
    logic         m_en_p, m_en_u, m_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [3:0] a, input logic [DW-1:0] d);
        req_addr[4*i +: 4]   = a;
        req_data[DW*i +: DW] = d;
    endtask

    // Apply the arbitration rules to the inputs present before the edge.
    task automatic model_edge();
        int w;
        int i;
        w = -1;
        if (clear) begin
            m_ptr = 0; m_last = -1; m_grant = '0; m_sel = '0; m_data = '0;
            m_en_p = 1'b0; m_en_u = 1'b0; m_busy = 1'b0;
        end else begin
            m_busy = 1'b0;
            for (int r = 0; r < N; r++)
                if (req[r] && r != m_last) m_busy = 1'b1;
            if (!stall) begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr + k) % N;
                    if (w < 0 && req[i] && i != m_last) w = i;
                end
            end
            if (w >= 0) begin
                m_grant = '0;
                m_grant[w] = 1'b1;
                m_sel  = req_addr[4*w +: 4];
                m_data = req_data[DW*w +: DW];
                m_en_p = (m_sel != 4'd0);
                m_en_u = 1'b1;
                m_ptr  = (w + 1) % N;
                m_last = w;
            end else begin
                m_grant = '0; m_en_p = 1'b0; m_en_u = 1'b0; m_last = -1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("grant_p", 64'(bus_p.grant), 64'(m_grant));
        check("wr_sel_p", 64'(bus_p.wr_sel), 64'(m_sel));
        check("wr_en_p", 64'(bus_p.wr_en), 64'(m_en_p));
        check("wr_data_p", 64'(bus_p.wr_data), 64'(m_data));
        check("busy_p", 64'(bus_p.busy), 64'(m_busy));
        check("grant_u", 64'(bus_u.grant), 64'(m_grant));
        check("wr_sel_u", 64'(bus_u.wr_sel), 64'(m_sel));
        check("wr_en_u", 64'(bus_u.wr_en), 64'(m_en_u));
    endtask

    initial begin
        logic [N-1:0] rr_exp [5];
        logic [3:0]   rs_exp [5];
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        rs_exp[0] = 4'd1; rs_exp[1] = 4'd2; rs_exp[2] = 4'd3;
        rs_exp[3] = 4'd4; rs_exp[4] = 4'd1;

        // Reset with every requester active
        clear = 1'b1; stall = 1'b0; req = '1;
        for (int i = 0; i < N; i++) set_lane(i, 4'(i + 1), 32'h1000_0000 + 32'(i));
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_grant", 64'(bus_p.grant), 64'h0);
            check("rst_wr_en", 64'(bus_p.wr_en), 64'h0);
            check("rst_wr_sel", 64'(bus_p.wr_sel), 64'h0);
        end

        // Round robin over all four, starting at requester 0
        clear = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("rr_grant", 64'(bus_p.grant), 64'(rr_exp[c]));
            check("rr_sel", 64'(bus_p.wr_sel), 64'(rs_exp[c]));
            check("rr_en", 64'(bus_p.wr_en), 64'h1);
        end

        // Lone requester is served every other cycle
        req = 4'b0100;
        set_lane(2, 4'd5, 32'hDEADBEEF);
        for (int c = 0; c < 6; c++) begin
            step();
            check("lone_grant", 64'(bus_p.grant), (c % 2 == 0) ? 64'h4 : 64'h0);
            check("lone_en", 64'(bus_p.wr_en), (c % 2 == 0) ? 64'h1 : 64'h0);
            check("lone_sel", 64'(bus_p.wr_sel), 64'h5);
            check("lone_data", 64'(bus_p.wr_data), 64'hDEADBEEF);
        end

        // Write to R0: accepted, strobe only when unprotected
        req = 4'b0010;
        set_lane(1, 4'd0, 32'hCAFE_0001);
        step();
        check("r0_grant", 64'(bus_p.grant), 64'h2);
        check("r0_en_prot", 64'(bus_p.wr_en), 64'h0);
        check("r0_en_unprot", 64'(bus_u.wr_en), 64'h1);
        check("r0_sel_unprot", 64'(bus_u.wr_sel), 64'h0);
        req = '0;
        step();

        // Stall for three cycles with two requests pending
        clear = 1'b1; step(); clear = 1'b0;
        req = 4'b0110; stall = 1'b1;
        set_lane(1, 4'd6, 32'h0000_0066);
        set_lane(2, 4'd7, 32'h0000_0077);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_grant", 64'(bus_p.grant), 64'h0);
            check("stall_en", 64'(bus_p.wr_en), 64'h0);
            check("stall_busy", 64'(bus_p.busy), 64'h1);
        end
        stall = 1'b0;
        step();
        check("unstall_g1", 64'(bus_p.grant), 64'h2);
        step();
        check("unstall_g2", 64'(bus_p.grant), 64'h4);

        // Clear in a cycle that carries grant[3]
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_lane(i, 4'(i + 1), 32'h2000_0000 + 32'(i));
        step();
        check("pre_clr_grant", 64'(bus_p.grant), 64'h8);
        clear = 1'b1;
        step();
        check("clr_grant", 64'(bus_p.grant), 64'h0);
        check("clr_en", 64'(bus_p.wr_en), 64'h0);
        check("clr_sel", 64'(bus_p.wr_sel), 64'h0);
        check("clr_data", 64'(bus_p.wr_data), 64'h0);
        check("clr_busy", 64'(bus_p.busy), 64'h0);
        clear = 1'b0;
        step();
        check("post_clr_grant", 64'(bus_p.grant), 64'h1);

        // Randomised traffic obeying the hold-until-granted handshake
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_grant[i] || !req[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    set_lane(i, 4'($urandom_range(0, 15)), $urandom);
                end
            end
            stall = ($urandom_range(0, 5) == 0);
            clear = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
